// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Four-phase (Q1..Q4) instruction sequencer for a PIC16F-style core. Each
//   instruction cycle spans four clocks. The instruction register (IR) and
//   the flush flag load together at the Q4->Q1 edge. Decode is purely
//   combinational from IR, so it stays stable for the whole cycle.
//   Skips and branches are resolved by turning the following cycle into a
//   forced NOP (flush).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   instr_in[13:0]            prefetched program word at PC
//   alu_bit_test_res          bit-test outcome, valid in Q3/Q4
//   alu_zero                  ALU result is zero, valid in Q3/Q4
//   q_phase[1:0]              current phase, 0=Q1 .. 3=Q4
//   alu_op[3:0], alu_d        ALU operation and destination (0=W, 1=f)
//   alu_b_in[2:0]             bit index for bit operations
//   lit_sel, lit[7:0]         literal operand select and value
//   f_addr                    register-file address
//   f_rd_en                   register read strobe (Q2)
//   alu_d_wr_en               result write strobe (Q4)
//   alu_status_wr_en          status update strobe (Q4)
//   pc_inc, pc_load           PC increment / load strobes (Q4)
//   pc_load_addr              branch target from IR
//   pc_from_stack             pc_load takes the top of stack
//   stack_push, stack_pop     call/return stack strobes (Q4)
//   flush_active              current cycle is a forced NOP
module instr_sequencer #(
  parameter int PC_W     = 11,
  parameter int F_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [13:0]         instr_in,
  input  logic                alu_bit_test_res,
  input  logic                alu_zero,
  output logic [1:0]          q_phase,
  output logic [3:0]          alu_op,
  output logic                alu_d,
  output logic                alu_d_wr_en,
  output logic                alu_status_wr_en,
  output logic [2:0]          alu_b_in,
  output logic                lit_sel,
  output logic [7:0]          lit,
  output logic [F_ADDR_W-1:0] f_addr,
  output logic                f_rd_en,
  output logic                pc_inc,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_load_addr,
  output logic                pc_from_stack,
  output logic                stack_push,
  output logic                stack_pop,
  output logic                flush_active
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_COM    = 4'd5;
  localparam logic [3:0] ALU_INC    = 4'd6;
  localparam logic [3:0] ALU_DEC    = 4'd7;
  localparam logic [3:0] ALU_RLF    = 4'd8;
  localparam logic [3:0] ALU_RRF    = 4'd9;
  localparam logic [3:0] ALU_SWAP   = 4'd10;
  localparam logic [3:0] ALU_PASSLF = 4'd11;
  localparam logic [3:0] ALU_PASSW  = 4'd12;
  localparam logic [3:0] ALU_ZERO   = 4'd13;
  localparam logic [3:0] ALU_BC     = 4'd14;
  localparam logic [3:0] ALU_BS     = 4'd15;

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

  phase_t      phase, phase_nxt;
  logic [13:0] ir;
  logic        flush;
  logic        next_flush;

  logic [3:0]  dec_op;
  logic        dec_d, dec_lit_sel, dec_rd, dec_wr, dec_st;
  logic        dec_load, dec_from_stack, dec_push, dec_pop;
  logic        dec_branch, dec_skip_z, dec_skip_bit;
  logic        live_q4;

  // State: phase counter, IR and flush flag
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= Q1;
      ir    <= 14'h0000;
      flush <= 1'b1;
    end else begin
      phase <= phase_nxt;
      if (phase == Q4) begin
        ir    <= instr_in;
        flush <= next_flush;
      end
    end
  end

  // Decode from IR
  always_comb begin
    dec_op         = ALU_PASSW;
    dec_d          = 1'b0;
    dec_lit_sel    = 1'b0;
    dec_rd         = 1'b0;
    dec_wr         = 1'b0;
    dec_st         = 1'b0;
    dec_load       = 1'b0;
    dec_from_stack = 1'b0;
    dec_push       = 1'b0;
    dec_pop        = 1'b0;
    dec_branch     = 1'b0;
    dec_skip_z     = 1'b0;
    dec_skip_bit   = 1'b0;
    case (ir[13:12])
      2'b00: begin
        dec_d = ir[7];
        case (ir[11:8])
          4'h0: begin
            if (ir[7]) begin
              // MOVWF: W to f, flags untouched
              dec_op = ALU_PASSW;
              dec_d  = 1'b1;
              dec_wr = 1'b1;
            end else if (ir[6:0] == 7'h08) begin
              // RETURN
              dec_load       = 1'b1;
              dec_from_stack = 1'b1;
              dec_pop        = 1'b1;
              dec_branch     = 1'b1;
            end
            // NOP, RETFIE, SLEEP, CLRWDT and the rest fall through as NOP
          end
          4'h1: begin dec_op = ALU_ZERO;   dec_wr = 1'b1; dec_st = 1'b1; end
          4'h2: begin dec_op = ALU_SUB;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h3: begin dec_op = ALU_DEC;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h4: begin dec_op = ALU_OR;     dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h5: begin dec_op = ALU_AND;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h6: begin dec_op = ALU_XOR;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h7: begin dec_op = ALU_ADD;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h8: begin dec_op = ALU_PASSLF; dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'h9: begin dec_op = ALU_COM;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'hA: begin dec_op = ALU_INC;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'hB: begin dec_op = ALU_DEC;    dec_rd = 1'b1; dec_wr = 1'b1; dec_skip_z = 1'b1; end
          // Rotates keep the status strobe; the ALU restricts the update to C
          4'hC: begin dec_op = ALU_RRF;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'hD: begin dec_op = ALU_RLF;    dec_rd = 1'b1; dec_wr = 1'b1; dec_st = 1'b1; end
          4'hE: begin dec_op = ALU_SWAP;   dec_rd = 1'b1; dec_wr = 1'b1; end
          default: begin dec_op = ALU_INC; dec_rd = 1'b1; dec_wr = 1'b1; dec_skip_z = 1'b1; end
        endcase
      end
      2'b01: begin
        // Bit ops always target f; the tests only read f and decide a skip
        dec_d  = 1'b1;
        dec_rd = 1'b1;
        dec_op = ir[10] ? ALU_BS : ALU_BC;
        if (ir[11]) dec_skip_bit = 1'b1;
        else        dec_wr       = 1'b1;
      end
      2'b10: begin
        dec_load   = 1'b1;
        dec_branch = 1'b1;
        dec_push   = ~ir[11];
      end
      default: begin
        dec_lit_sel = 1'b1;
        dec_wr      = 1'b1;
        case (ir[11:8])
          4'h0, 4'h1, 4'h2, 4'h3: dec_op = ALU_PASSLF;
          4'h4, 4'h5, 4'h6, 4'h7: begin
            dec_op         = ALU_PASSLF;
            dec_load       = 1'b1;
            dec_from_stack = 1'b1;
            dec_pop        = 1'b1;
            dec_branch     = 1'b1;
          end
          4'h8: begin dec_op = ALU_OR;  dec_st = 1'b1; end
          4'h9: begin dec_op = ALU_AND; dec_st = 1'b1; end
          4'hA: begin dec_op = ALU_XOR; dec_st = 1'b1; end
          4'hB: begin dec_lit_sel = 1'b0; dec_wr = 1'b0; end
          4'hC, 4'hD: begin dec_op = ALU_SUB; dec_st = 1'b1; end
          default: begin dec_op = ALU_ADD; dec_st = 1'b1; end
        endcase
      end
    endcase
  end

  // Next phase, strobes and flush resolution
  always_comb begin
    case (phase)
      Q1:      phase_nxt = Q2;
      Q2:      phase_nxt = Q3;
      Q3:      phase_nxt = Q4;
      default: phase_nxt = Q1;
    endcase

    // A flushed cycle cannot request another flush, so skips never chain
    next_flush = ~flush & (dec_branch | (dec_skip_z & alu_zero) |
                           (dec_skip_bit & alu_bit_test_res));

    live_q4          = ~rst & ~flush & (phase == Q4);
    q_phase          = phase;
    flush_active     = flush;
    alu_op           = dec_op;
    alu_d            = dec_d;
    alu_b_in         = ir[9:7];
    lit_sel          = dec_lit_sel;
    lit              = ir[7:0];
    f_addr           = ir[F_ADDR_W-1:0];
    pc_load_addr     = ir[PC_W-1:0];
    f_rd_en          = ~rst & (phase == Q2) & dec_rd;
    alu_d_wr_en      = live_q4 & dec_wr;
    alu_status_wr_en = live_q4 & dec_st;
    pc_load          = live_q4 & dec_load;
    pc_from_stack    = live_q4 & dec_from_stack;
    stack_push       = live_q4 & dec_push;
    stack_pop        = live_q4 & dec_pop;
    pc_inc           = ~rst & (phase == Q4) & ~(live_q4 & dec_load);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Bench for instr_sequencer. A table of back-to-back instructions, each
//   with the ALU feedback it sees and its expected decode, is streamed into
//   the DUT. The expectation for each word is queued when the word is
//   presented on instr_in and popped when that word executes one cycle
//   later. Reset, including reset landing mid-instruction, is exercised by
//   hand-written sequences.
module tb_instr_sequencer;

  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_COM = 5;
  localparam int A_INC = 6, A_DEC = 7, A_RLF = 8, A_RRF = 9, A_SWAP = 10;
  localparam int A_PASSLF = 11, A_PASSW = 12, A_ZERO = 13, A_BC = 14, A_BS = 15;
  localparam int DC = -1;  // don't care
  localparam int N = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] instr_in = 14'h0000;
  logic        alu_bit_test_res = 1'b0;
  logic        alu_zero = 1'b0;
  logic [1:0]  q_phase;
  logic [3:0]  alu_op;
  logic        alu_d, alu_d_wr_en, alu_status_wr_en;
  logic [2:0]  alu_b_in;
  logic        lit_sel;
  logic [7:0]  lit;
  logic [6:0]  f_addr;
  logic        f_rd_en, pc_inc, pc_load;
  logic [10:0] pc_load_addr;
  logic        pc_from_stack, stack_push, stack_pop, flush_active;

  instr_sequencer #(.PC_W(11), .F_ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .alu_bit_test_res(alu_bit_test_res), .alu_zero(alu_zero),
    .q_phase(q_phase), .alu_op(alu_op), .alu_d(alu_d),
    .alu_d_wr_en(alu_d_wr_en), .alu_status_wr_en(alu_status_wr_en),
    .alu_b_in(alu_b_in), .lit_sel(lit_sel), .lit(lit), .f_addr(f_addr),
    .f_rd_en(f_rd_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .pc_from_stack(pc_from_stack),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .flush_active(flush_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] instr;
    bit br;  bit z;  bit fl;
    int op;  int d;  int ls; int rd;
    bit wr;  bit st; bit ld; bit fs; bit push; bit pop;
  } vec_t;

  vec_t tbl[N];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input int ph, input vec_t e);
    bit q4, live;
    q4   = (ph == 3);
    live = q4 && !e.fl;
    chk("q_phase", int'(q_phase), ph);
    chk("flush_active", int'(flush_active), int'(e.fl));
    if (e.op >= 0) chk("alu_op", int'(alu_op), e.op);
    if (e.d  >= 0) chk("alu_d", int'(alu_d), e.d);
    if (e.ls >= 0) chk("lit_sel", int'(lit_sel), e.ls);
    chk("lit", int'(lit), int'(e.instr[7:0]));
    chk("f_addr", int'(f_addr), int'(e.instr[6:0]));
    chk("pc_load_addr", int'(pc_load_addr), int'(e.instr[10:0]));
    chk("alu_b_in", int'(alu_b_in), int'(e.instr[9:7]));
    if (ph != 1) chk("f_rd_en_idle", int'(f_rd_en), 0);
    else if (!e.fl && e.rd >= 0) chk("f_rd_en", int'(f_rd_en), e.rd);
    chk("alu_d_wr_en", int'(alu_d_wr_en), int'(live && e.wr));
    chk("alu_status_wr_en", int'(alu_status_wr_en), int'(live && e.st));
    chk("pc_load", int'(pc_load), int'(live && e.ld));
    chk("pc_from_stack", int'(pc_from_stack), int'(live && e.fs));
    chk("stack_push", int'(stack_push), int'(live && e.push));
    chk("stack_pop", int'(stack_pop), int'(live && e.pop));
    chk("pc_inc", int'(pc_inc), int'(q4 && !(live && e.ld)));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wr"}, int'(alu_d_wr_en), 0);
    chk({tag, "_status"}, int'(alu_status_wr_en), 0);
    chk({tag, "_pc_load"}, int'(pc_load), 0);
    chk({tag, "_push"}, int'(stack_push), 0);
    chk({tag, "_pop"}, int'(stack_pop), 0);
    chk({tag, "_pc_inc"}, int'(pc_inc), 0);
    chk({tag, "_f_rd_en"}, int'(f_rd_en), 0);
  endtask

  // Hold reset 3 clocks, checking the reset state, then release at Q1.
  task automatic do_reset();
    rst = 1'b1;
    instr_in = 14'h0000;
    alu_bit_test_res = 1'b0;
    alu_zero = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_q_phase", int'(q_phase), 0);
      chk("rst_flush", int'(flush_active), 1);
      chk_quiet("rst");
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e, rst_exp;
    //            instr     br z fl  op        d   ls  rd  wr st ld fs pu po
    tbl[0]  = '{14'h07A0, 1, 1, 0, A_ADD,    1,  0,  1,  1, 1, 0, 0, 0, 0};  // ADDWF 0x20,1
    tbl[1]  = '{14'h3055, 1, 1, 0, A_PASSLF, 0,  1,  0,  1, 0, 0, 0, 0, 0};  // MOVLW 0x55
    tbl[2]  = '{14'h1903, 1, 0, 0, A_BC,     DC, 0,  1,  0, 0, 0, 0, 0, 0};  // BTFSC 3,2 skip
    tbl[3]  = '{14'h3E01, 1, 1, 1, A_ADD,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // ADDLW flushed
    tbl[4]  = '{14'h1903, 0, 1, 0, A_BC,     DC, 0,  1,  0, 0, 0, 0, 0, 0};  // BTFSC no skip
    tbl[5]  = '{14'h3E01, 1, 1, 0, A_ADD,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // ADDLW runs
    tbl[6]  = '{14'h2010, 1, 1, 0, DC,       DC, DC, 0,  0, 0, 1, 0, 1, 0};  // CALL 0x010
    tbl[7]  = '{14'h0000, 1, 1, 1, DC,       DC, DC, 0,  0, 0, 0, 0, 0, 0};  // NOP flushed
    tbl[8]  = '{14'h0008, 1, 1, 0, DC,       DC, DC, 0,  0, 0, 1, 1, 0, 1};  // RETURN
    tbl[9]  = '{14'h07A0, 1, 1, 1, A_ADD,    1,  0,  1,  1, 1, 0, 0, 0, 0};  // ADDWF flushed
    tbl[10] = '{14'h0BA1, 0, 1, 0, A_DEC,    1,  0,  1,  1, 0, 0, 0, 0, 0};  // DECFSZ z=1
    tbl[11] = '{14'h1D03, 1, 1, 1, A_BS,     DC, 0,  1,  0, 0, 0, 0, 0, 0};  // BTFSS flushed
    tbl[12] = '{14'h3E01, 1, 1, 0, A_ADD,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // ADDLW runs
    tbl[13] = '{14'h0F21, 1, 0, 0, A_INC,    0,  0,  1,  1, 0, 0, 0, 0, 0};  // INCFSZ z=0
    tbl[14] = '{14'h00A2, 1, 1, 0, A_PASSW,  1,  0,  0,  1, 0, 0, 0, 0, 0};  // MOVWF 0x22
    tbl[15] = '{14'h01A3, 1, 1, 0, A_ZERO,   1,  0,  DC, 1, 1, 0, 0, 0, 0};  // CLRF 0x23
    tbl[16] = '{14'h0EA4, 1, 1, 0, A_SWAP,   1,  0,  1,  1, 0, 0, 0, 0, 0};  // SWAPF 0x24,1
    tbl[17] = '{14'h15A5, 1, 1, 0, A_BS,     DC, 0,  1,  1, 0, 0, 0, 0, 0};  // BSF 0x25,3
    tbl[18] = '{14'h2923, 1, 1, 0, DC,       DC, DC, 0,  0, 0, 1, 0, 0, 0};  // GOTO 0x123
    tbl[19] = '{14'h390F, 1, 1, 1, A_AND,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // ANDLW flushed
    tbl[20] = '{14'h345A, 1, 1, 0, A_PASSLF, 0,  1,  0,  1, 0, 1, 1, 0, 1};  // RETLW 0x5A
    tbl[21] = '{14'h3AFF, 1, 1, 1, A_XOR,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // XORLW flushed
    tbl[22] = '{14'h3880, 1, 1, 0, A_OR,     0,  1,  0,  1, 1, 0, 0, 0, 0};  // IORLW 0x80
    tbl[23] = '{14'h0230, 1, 1, 0, A_SUB,    0,  0,  1,  1, 1, 0, 0, 0, 0};  // SUBWF 0x30,0
    tbl[24] = '{14'h0063, 1, 1, 0, DC,       DC, DC, 0,  0, 0, 0, 0, 0, 0};  // SLEEP as NOP
    tbl[25] = '{14'h13A6, 1, 1, 0, A_BC,     DC, 0,  1,  1, 0, 0, 0, 0, 0};  // BCF 0x26,7
    tbl[26] = '{14'h3C10, 1, 1, 0, A_SUB,    0,  1,  0,  1, 1, 0, 0, 0, 0};  // SUBLW 0x10
    rst_exp = '{14'h0000, 0, 0, 1, DC, DC, DC, 0, 0, 0, 0, 0, 0, 0};

    // Table stream: cycle c executes tbl[c-1] (cycle 0 is the post-reset NOP)
    do_reset();
    sb.push_back(rst_exp);
    for (int c = 0; c <= N; c++) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
        e = rst_exp;
      end else begin
        e = sb.pop_front();
      end
      instr_in = (c < N) ? tbl[c].instr : 14'h0000;
      if (c < N) sb.push_back(tbl[c]);
      alu_bit_test_res = (c > 0) ? tbl[c-1].br : 1'b0;
      alu_zero         = (c > 0) ? tbl[c-1].z  : 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        check_phase(ph, e);
        step();
      end
    end

    // Reset arriving in Q3 of ADDWF: no Q4 write follows
    do_reset();
    instr_in = 14'h07A0;
    alu_zero = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("mid_q1_flush", int'(flush_active), 0);
    step();
    @(negedge clk);
    chk("mid_q2_f_rd_en", int'(f_rd_en), 1);
    step();
    @(negedge clk);
    chk("mid_q3_phase", int'(q_phase), 2);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_after_phase", int'(q_phase), 0);
    chk("mid_after_flush", int'(flush_active), 1);
    chk_quiet("mid_after");
    rst = 1'b0;
    // Post-reset cycle is a flushed NOP: Q4 shows only pc_inc
    for (int ph = 0; ph < 4; ph++) begin
      step();
      @(negedge clk);
      if (ph == 2) begin
        chk("mid_nop_wr", int'(alu_d_wr_en), 0);
        chk("mid_nop_pc_inc", int'(pc_inc), 1);
      end
    end
    // Now the ADDWF executes; reset raised during its Q4 masks every strobe
    step();
    step();
    step();
    @(negedge clk);
    chk("q4_phase", int'(q_phase), 3);
    chk("q4_wr_before_rst", int'(alu_d_wr_en), 1);
    step();
    step();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("q4rst_phase", int'(q_phase), 3);
    chk_quiet("q4rst");
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
